// File: rtl/tcp_rx_op_queue_pkg.sv
// Shared TCP receive-side definitions: flag positions, default port,
// and the descriptor layout that the queue stores.
package tcp_pkg;

    // Flag bit positions within the 6-bit flags field
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;

    localparam logic [15:0] LOCAL_PORT_DEF = 16'hF718;

    localparam int PORT_W  = 16;
    localparam int FLAGS_W = 6;
    localparam int OPT_W   = 96;
    localparam int SEQ_W   = 32;
    localparam int LEN_W   = 16;
    localparam int WIN_W   = 16;
    localparam int DESC_W  = 2*PORT_W + FLAGS_W + OPT_W + 2*SEQ_W + LEN_W + WIN_W;

    // Descriptor as stored in the FIFO, source port in the MSBs
    typedef struct packed {
        logic [PORT_W-1:0]  src_port;
        logic [PORT_W-1:0]  dst_port;
        logic [FLAGS_W-1:0] flags;
        logic [OPT_W-1:0]   options;
        logic [SEQ_W-1:0]   seq_num;
        logic [SEQ_W-1:0]   ack_num;
        logic [LEN_W-1:0]   data_len;
        logic [WIN_W-1:0]   window;
    } tcp_desc_t;

    function automatic logic [DESC_W-1:0] desc_pack(input tcp_desc_t d);
        return d;
    endfunction

    function automatic tcp_desc_t desc_unpack(input logic [DESC_W-1:0] v);
        return tcp_desc_t'(v);
    endfunction

endpackage

// File: rtl/tcp_desc_fifo.sv
// Generic show-ahead synchronous FIFO. Head entry is read combinationally
// from the RAM at the read pointer; pointers carry one extra wrap bit.
module tcp_desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write
    assign push  = wr_en && (!full || pop);
    assign level = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap bit handled by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tcp_rx_op_queue.sv
// Filters parsed TCP segments by checksum and destination port, queues
// accepted descriptors for the connection controller, counts drops.
module tcp_rx_op_queue
    import tcp_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] LOCAL_PORT = LOCAL_PORT_DEF,
    parameter int          CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_hdr_vld_i,
    input  logic                   rx_csum_ok_i,
    input  logic [15:0]            rx_source_port_i,
    input  logic [15:0]            rx_dest_port_i,
    input  logic [5:0]             rx_flags_i,
    input  logic [95:0]            rx_options_i,
    input  logic [31:0]            rx_seq_num_i,
    input  logic [31:0]            rx_ack_num_i,
    input  logic [15:0]            rx_data_len_i,
    input  logic [15:0]            rx_window_i,
    output logic                   tcp_op_rcv_o,
    output logic [15:0]            tcp_source_port_o,
    output logic [15:0]            tcp_dest_port_o,
    output logic [5:0]             tcp_flags_o,
    output logic [95:0]            tcp_options_o,
    output logic [31:0]            tcp_seq_num_o,
    output logic [31:0]            tcp_ack_num_o,
    output logic [15:0]            tcp_data_len_o,
    output logic [15:0]            tcp_window_o,
    input  logic                   tcp_op_rcv_rd_i,
    output logic [$clog2(DEPTH):0] q_level_o,
    output logic [CNT_W-1:0]       drop_port_cnt_o,
    output logic [CNT_W-1:0]       drop_csum_cnt_o,
    output logic [CNT_W-1:0]       drop_full_cnt_o
);
    tcp_desc_t              in_desc, head;
    logic [DESC_W-1:0]      head_vec;
    logic                   full, empty, pop_now, accept;
    logic                   drop_csum, drop_port, drop_full;
    logic [CNT_W-1:0]       cnt_max;

    assign cnt_max = {CNT_W{1'b1}};

    // Assemble the incoming descriptor from the parser fields
    always_comb begin
        in_desc          = '0;
        in_desc.src_port = rx_source_port_i;
        in_desc.dst_port = rx_dest_port_i;
        in_desc.flags    = rx_flags_i;
        in_desc.options  = rx_options_i;
        in_desc.seq_num  = rx_seq_num_i;
        in_desc.ack_num  = rx_ack_num_i;
        in_desc.data_len = rx_data_len_i;
        in_desc.window   = rx_window_i;
    end

    // Filter in priority order: checksum, then port, then space
    assign pop_now   = tcp_op_rcv_rd_i && !empty;
    assign drop_csum = rx_hdr_vld_i && !rx_csum_ok_i;
    assign drop_port = rx_hdr_vld_i && rx_csum_ok_i && (rx_dest_port_i != LOCAL_PORT);
    assign drop_full = rx_hdr_vld_i && rx_csum_ok_i && (rx_dest_port_i == LOCAL_PORT)
                       && full && !pop_now;
    assign accept    = rx_hdr_vld_i && rx_csum_ok_i && (rx_dest_port_i == LOCAL_PORT)
                       && (!full || pop_now);

    tcp_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (desc_pack(in_desc)),
        .rd_en   (tcp_op_rcv_rd_i),
        .rd_data (head_vec),
        .full    (full),
        .empty   (empty),
        .level   (q_level_o)
    );

    assign head              = desc_unpack(head_vec);
    assign tcp_op_rcv_o      = !empty;
    assign tcp_source_port_o = head.src_port;
    assign tcp_dest_port_o   = head.dst_port;
    assign tcp_flags_o       = head.flags;
    assign tcp_options_o     = head.options;
    assign tcp_seq_num_o     = head.seq_num;
    assign tcp_ack_num_o     = head.ack_num;
    assign tcp_data_len_o    = head.data_len;
    assign tcp_window_o      = head.window;

    // Saturating drop counters; at most one bumps per strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_port_cnt_o <= '0;
            drop_csum_cnt_o <= '0;
            drop_full_cnt_o <= '0;
        end else begin
            if (drop_csum && drop_csum_cnt_o != cnt_max) drop_csum_cnt_o <= drop_csum_cnt_o + 1'b1;
            if (drop_port && drop_port_cnt_o != cnt_max) drop_port_cnt_o <= drop_port_cnt_o + 1'b1;
            if (drop_full && drop_full_cnt_o != cnt_max) drop_full_cnt_o <= drop_full_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_tcp_rx_op_queue.sv
// Directed bench for tcp_rx_op_queue (DEPTH=4, CNT_W=4).
module tb_tcp_rx_op_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_hdr_vld_i, rx_csum_ok_i;
    logic [15:0] rx_source_port_i, rx_dest_port_i;
    logic [5:0]  rx_flags_i;
    logic [95:0] rx_options_i;
    logic [31:0] rx_seq_num_i, rx_ack_num_i;
    logic [15:0] rx_data_len_i, rx_window_i;
    logic        tcp_op_rcv_o;
    logic [15:0] tcp_source_port_o, tcp_dest_port_o;
    logic [5:0]  tcp_flags_o;
    logic [95:0] tcp_options_o;
    logic [31:0] tcp_seq_num_o, tcp_ack_num_o;
    logic [15:0] tcp_data_len_o, tcp_window_o;
    logic        tcp_op_rcv_rd_i;
    logic [2:0]  q_level_o;
    logic [3:0]  drop_port_cnt_o, drop_csum_cnt_o, drop_full_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tcp_rx_op_queue #(.DEPTH(4), .LOCAL_PORT(16'hF718), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rx_hdr_vld_i(rx_hdr_vld_i), .rx_csum_ok_i(rx_csum_ok_i),
        .rx_source_port_i(rx_source_port_i), .rx_dest_port_i(rx_dest_port_i),
        .rx_flags_i(rx_flags_i), .rx_options_i(rx_options_i),
        .rx_seq_num_i(rx_seq_num_i), .rx_ack_num_i(rx_ack_num_i),
        .rx_data_len_i(rx_data_len_i), .rx_window_i(rx_window_i),
        .tcp_op_rcv_o(tcp_op_rcv_o),
        .tcp_source_port_o(tcp_source_port_o), .tcp_dest_port_o(tcp_dest_port_o),
        .tcp_flags_o(tcp_flags_o), .tcp_options_o(tcp_options_o),
        .tcp_seq_num_o(tcp_seq_num_o), .tcp_ack_num_o(tcp_ack_num_o),
        .tcp_data_len_o(tcp_data_len_o), .tcp_window_o(tcp_window_o),
        .tcp_op_rcv_rd_i(tcp_op_rcv_rd_i),
        .q_level_o(q_level_o),
        .drop_port_cnt_o(drop_port_cnt_o), .drop_csum_cnt_o(drop_csum_cnt_o),
        .drop_full_cnt_o(drop_full_cnt_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one strobe for one cycle (rd optionally pulsed in the same cycle)
    task automatic strobe(input logic [31:0] seq, input logic [15:0] port,
                          input logic csum, input logic rd);
        rx_hdr_vld_i     = 1'b1;
        rx_csum_ok_i     = csum;
        rx_dest_port_i   = port;
        rx_seq_num_i     = seq;
        tcp_op_rcv_rd_i  = rd;
        tick();
        rx_hdr_vld_i     = 1'b0;
        tcp_op_rcv_rd_i  = 1'b0;
    endtask

    task automatic pop();
        tcp_op_rcv_rd_i = 1'b1;
        tick();
        tcp_op_rcv_rd_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx_hdr_vld_i = 0; rx_csum_ok_i = 0; rx_source_port_i = 0; rx_dest_port_i = 0;
        rx_flags_i = 0; rx_options_i = 0; rx_seq_num_i = 0; rx_ack_num_i = 0;
        rx_data_len_i = 0; rx_window_i = 0; tcp_op_rcv_rd_i = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_vld",   tcp_op_rcv_o, 0);
        chk("rst_level", q_level_o, 0);
        chk("rst_cnts",  {drop_port_cnt_o, drop_csum_cnt_o, drop_full_cnt_o}, 0);

        // Basic path with every field distinct
        rx_source_port_i = 16'h1234;
        rx_flags_i       = 6'h02;
        rx_options_i     = 96'hA5A5_0102_0304_0506_0708_090A;
        rx_ack_num_i     = 32'h2000_0001;
        rx_data_len_i    = 16'd512;
        rx_window_i      = 16'hFFF0;
        strobe(32'h1000_0000, 16'hF718, 1'b1, 1'b0);
        chk("basic_vld",   tcp_op_rcv_o, 1);
        chk("basic_src",   tcp_source_port_o, 16'h1234);
        chk("basic_dst",   tcp_dest_port_o, 16'hF718);
        chk("basic_flags", tcp_flags_o, 6'h02);
        chk("basic_opt",   tcp_options_o, 96'hA5A5_0102_0304_0506_0708_090A);
        chk("basic_seq",   tcp_seq_num_o, 32'h1000_0000);
        chk("basic_ack",   tcp_ack_num_o, 32'h2000_0001);
        chk("basic_len",   tcp_data_len_o, 16'd512);
        chk("basic_win",   tcp_window_o, 16'hFFF0);
        chk("basic_lvl1",  q_level_o, 1);
        pop();
        chk("basic_empty", tcp_op_rcv_o, 0);
        chk("basic_lvl0",  q_level_o, 0);

        // Filtering: bad port, bad checksum, both bad
        strobe(32'h11, 16'h0050, 1'b1, 1'b0);
        strobe(32'h12, 16'hF718, 1'b0, 1'b0);
        chk("filt_port1", drop_port_cnt_o, 1);
        chk("filt_csum1", drop_csum_cnt_o, 1);
        strobe(32'h13, 16'h0050, 1'b0, 1'b0);
        chk("filt_both_port", drop_port_cnt_o, 1);
        chk("filt_both_csum", drop_csum_cnt_o, 2);
        chk("filt_empty", tcp_op_rcv_o, 0);
        chk("filt_full0", drop_full_cnt_o, 0);

        // Overfill: five strobes into four slots
        for (int i = 1; i <= 5; i++) strobe(i, 16'hF718, 1'b1, 1'b0);
        chk("full_lvl",  q_level_o, 4);
        chk("full_drop", drop_full_cnt_o, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_vld%0d", i), tcp_op_rcv_o, 1);
            chk($sformatf("drain_seq%0d", i), tcp_seq_num_o, i);
            pop();
        end
        chk("drain_empty", tcp_op_rcv_o, 0);

        // Full with simultaneous pop accepts the new descriptor
        for (int i = 5; i <= 8; i++) strobe(i, 16'hF718, 1'b1, 1'b0);
        chk("fp_lvl_pre", q_level_o, 4);
        chk("fp_head",    tcp_seq_num_o, 5);
        strobe(9, 16'hF718, 1'b1, 1'b1);
        chk("fp_lvl",  q_level_o, 4);
        chk("fp_drop", drop_full_cnt_o, 1);
        for (int i = 6; i <= 9; i++) begin
            chk($sformatf("fp_seq%0d", i), tcp_seq_num_o, i);
            pop();
        end
        chk("fp_empty", tcp_op_rcv_o, 0);

        // Pop on empty is ignored
        pop();
        chk("rde_vld", tcp_op_rcv_o, 0);
        chk("rde_lvl", q_level_o, 0);

        // One entry + simultaneous accept/pop: new entry shows next cycle
        strobe(32'hA, 16'hF718, 1'b1, 1'b0);
        strobe(32'hB, 16'hF718, 1'b1, 1'b1);
        chk("one_vld", tcp_op_rcv_o, 1);
        chk("one_seq", tcp_seq_num_o, 32'hB);
        chk("one_lvl", q_level_o, 1);
        pop();

        // Counter saturation at 4'hF
        for (int i = 0; i < 20; i++) strobe(i, 16'hF718, 1'b0, 1'b0);
        chk("sat_csum", drop_csum_cnt_o, 4'hF);
        chk("sat_port", drop_port_cnt_o, 1);

        // Reset with entries queued
        for (int i = 0; i < 3; i++) strobe(i, 16'hF718, 1'b1, 1'b0);
        chk("prerst_lvl", q_level_o, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_vld",  tcp_op_rcv_o, 0);
        chk("mrst_lvl",  q_level_o, 0);
        chk("mrst_cnts", {drop_port_cnt_o, drop_csum_cnt_o, drop_full_cnt_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tcp_rx_op_queue.md
Name: tcp_rx_op_queue

Overview:
- Sits directly upstream of the TCP connection controller.
- Accepts one descriptor per received TCP segment from the TCP header parser, with the descriptor and the checksum verdict arriving in one strobe.
- Filters segments by destination port and checksum, buffers accepted descriptors in a small FIFO, and presents the head to the controller as a level-valid / pulse-read operation.
- Keeps saturating drop counters for debug.

Parameters:
- DEPTH, 4: number of descriptor slots; power of 2, range 2..16.
- LOCAL_PORT, 16'hF718: accepted destination port (63256).
- CNT_W, 16: width of each drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_hdr_vld_i  in  1  one-cycle strobe; segment fully received, fields below valid
- rx_csum_ok_i  in  1  TCP checksum verdict, sampled with rx_hdr_vld_i
- rx_source_port_i  in  16  segment source port
- rx_dest_port_i  in  16  segment destination port
- rx_flags_i  in  6  {URG,ACK,PSH,RST,SYN,FIN}, bit 5 to bit 0
- rx_options_i  in  96  raw option bytes
- rx_seq_num_i  in  32  sequence number
- rx_ack_num_i  in  32  acknowledgement number
- rx_data_len_i  in  16  payload bytes
- rx_window_i  in  16  advertised window
- tcp_op_rcv_o  out  1  head descriptor valid (FIFO non-empty)
- tcp_source_port_o, tcp_dest_port_o, tcp_flags_o, tcp_options_o, tcp_seq_num_o, tcp_ack_num_o, tcp_data_len_o, tcp_window_o  out  16/16/6/96/32/32/16/16  head descriptor fields
- tcp_op_rcv_rd_i  in  1  one-cycle pop pulse from the controller
- q_level_o  out  clog2(DEPTH)+1  current occupancy
- drop_port_cnt_o, drop_csum_cnt_o, drop_full_cnt_o  out  CNT_W  saturating drop counters

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, counters 0. Reset mid-operation discards all queued descriptors.
- Accept condition on rx_hdr_vld_i=1, evaluated in priority order:
  - rx_csum_ok_i=0: drop, drop_csum_cnt++.
  - else rx_dest_port_i != LOCAL_PORT: drop, drop_port_cnt++.
  - else FIFO full and no pop this cycle: drop, drop_full_cnt++.
  - else: write all fields (230 bits) at the write pointer.
- Exactly one counter increments per dropped strobe. Counters saturate at all-ones and never wrap.
- Write latency: a descriptor accepted in cycle N is visible with tcp_op_rcv_o=1 in cycle N+1 if the FIFO was empty.
- Output is show-ahead. Head fields are stable while tcp_op_rcv_o=1 and until the clock edge that ends the pop cycle. The controller samples fields in the same cycle it asserts tcp_op_rcv_rd_i.
- Pop: tcp_op_rcv_rd_i=1 with tcp_op_rcv_o=1 advances the read pointer at that edge. The next entry, or empty, appears in the following cycle.
- tcp_op_rcv_rd_i while empty is ignored: no pointer move, no error.
- Simultaneous accept and pop:
  - Occupancy unchanged.
  - When full, the new descriptor is accepted.
  - When the FIFO holds exactly one entry, the output shows the new entry next cycle.
- Pointers are clog2(DEPTH)+1 bits wide.
  - Full = MSBs differ and LSBs equal.
  - Empty = pointers equal.
  - Pointers wrap naturally.
- Field outputs when empty are don't-care, but are driven from the RAM at the read pointer (no X-gating needed); the bench checks fields only when tcp_op_rcv_o=1.
- q_level_o = wr_ptr - rd_ptr, registered to match the pointers.
- No combinational path from any rx_* input to any tcp_* output.

Decomposition:
- Package tcp_pkg holds:
  - flag bit indices (FLAG_FIN=0 through FLAG_URG=5);
  - LOCAL_PORT default;
  - descriptor field widths and the total descriptor width of 230;
  - pack/unpack ordering of the descriptor vector.
- One sub-module, tcp_desc_fifo: generic synchronous show-ahead FIFO (WIDTH, DEPTH) with full/empty/level.
- The filter and counters live in the top.

Test Plan:
- Basic path: one strobe with dest_port=16'hF718, csum_ok=1, flags=6'h02, seq=32'h1000_0000 -> tcp_op_rcv_o=1 next cycle with identical fields; rd pulse -> tcp_op_rcv_o=0 the cycle after, q_level_o=0.
- Filtering: strobes with dest_port=16'h0050 and with csum_ok=0 -> FIFO stays empty, drop_port_cnt_o=1, drop_csum_cnt_o=1. A strobe with bad port and bad checksum increments only drop_csum_cnt_o.
- Full: 5 valid strobes with seq 1..5 and DEPTH=4, no reads -> q_level_o=4, drop_full_cnt_o=1; draining yields seq 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, strobe seq=9 in the same cycle as rd -> accepted, level stays 4, drop_full_cnt_o unchanged, seq=9 is the last entry drained.
- Robustness: rd pulse while empty -> no change. With CNT_W=4, 20 bad-checksum strobes -> drop_csum_cnt_o=15. Reset asserted with 3 entries queued -> tcp_op_rcv_o=0, q_level_o=0, all counters 0 next cycle.
